// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
// State encoding, ALU select codes, default operand width and the Booth
// pair decode used by the controller.
package booth_pkg;

   // Default operand width (also the iteration count)
   localparam int BOOTH_WIDTH = 8;

   // Controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      OP    = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Datapath ALU select
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;

   // Per-cycle datapath control bundle
   typedef struct packed {
      logic       ld_en;
      logic [1:0] alu_op;
      logic       a_en;
      logic       shift_en;
   } dp_ctrl_t;

   localparam dp_ctrl_t DP_CTRL_IDLE = '{ld_en: 1'b0, alu_op: OP_NONE, a_en: 1'b0, shift_en: 1'b0};

   // Booth pair {Q[0],Q[-1]}: 10 subtracts M, 01 adds M, 00/11 leave A alone
   function automatic logic [1:0] booth_alu_op(input logic q0, input logic q_m1);
      logic [1:0] op;
      case ({q0, q_m1})
         2'b10:   op = OP_SUB;
         2'b01:   op = OP_ADD;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Iteration down-counter for the Booth sequencer.
// Clear beats load beats decrement; the decrement saturates at zero so the
// count can never wrap. 'last' flags the final iteration (cnt==1).
module booth_iter_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: clear, reload or saturating decrement
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the radix-2 Booth multiplier datapath.
// Drives load / accumulate / shift enables of the operand registers and runs
// one WIDTH-iteration multiply per accepted request, ending in a
// valid/ready handshake. Holds no operand data.
//
// Optional build macro BOOTH_SEQ_CTRL_SKIP_EN: when defined, an OP cycle whose
// Booth pair is 00/11 performs the shift itself instead of visiting SHIFT,
// so latency drops to WIDTH + (add/sub iterations) + 2.
//
// Only the state register and the iteration counter are flops; every output
// is a combinational decode of the state (plus {q0,q_m1} in OP).
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter  int WIDTH = BOOTH_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   input  logic       q0,
   input  logic       q_m1,
   output logic       ld_en,
   output logic [1:0] alu_op,
   output logic       a_en,
   output logic       shift_en,
   output logic       busy,
   output logic       out_valid,
   input  logic       out_ready
);

   state_e           state_d;
   state_e           state_q;
   logic             cnt_clr;
   logic             cnt_ld;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             pair_nop;
   dp_ctrl_t         ctrl;

   // A 00/11 pair means this iteration needs no ALU work
   assign pair_nop = (q0 == q_m1);

   booth_iter_cnt #(
      .CNT_W (CNT_W)
   ) u_iter_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (cnt_clr),
      .load     (cnt_ld),
      .load_val (CNT_W'(WIDTH)),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .last     (cnt_last)
   );

   // Next-state and counter control; abort outside IDLE overrides everything
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_ld  = 1'b0;
      cnt_dec = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_ld  = 1'b1;
            state_d = OP;
         end
         OP: begin
`ifdef BOOTH_SEQ_CTRL_SKIP_EN
            if (pair_nop) begin
               cnt_dec = 1'b1;
               state_d = cnt_last ? DONE : OP;
            end else begin
               state_d = SHIFT;
            end
`else
            state_d = SHIFT;
`endif
         end
         SHIFT: begin
            cnt_dec = 1'b1;
            state_d = cnt_last ? DONE : OP;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
         cnt_ld  = 1'b0;
         cnt_dec = 1'b0;
      end
   end

   // Datapath enable decode from the current state and Booth pair
   always_comb begin
      ctrl = DP_CTRL_IDLE;
      case (state_q)
         LOAD: begin
            ctrl.ld_en = 1'b1;
         end
         OP: begin
            ctrl.alu_op = booth_alu_op(q0, q_m1);
            ctrl.a_en   = !pair_nop;
`ifdef BOOTH_SEQ_CTRL_SKIP_EN
            ctrl.shift_en = pair_nop;
`endif
         end
         SHIFT: begin
            ctrl.shift_en = 1'b1;
         end
         default: begin
            ctrl = DP_CTRL_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign ld_en     = ctrl.ld_en;
   assign alu_op    = ctrl.alu_op;
   assign a_en      = ctrl.a_en;
   assign shift_en  = ctrl.shift_en;
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);

   // Structural invariants of the sequencer
   a_no_acc_and_shift : assert property (@(posedge clk) disable iff (!reset_n) !(a_en && shift_en));
   a_ld_only_in_load  : assert property (@(posedge clk) disable iff (!reset_n) ld_en |-> (state_q == LOAD));
   a_shift_cnt_nz     : assert property (@(posedge clk) disable iff (!reset_n) (state_q == SHIFT) |-> (cnt != '0));

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: drives the controller together with a small
// behavioural Booth datapath (enable-gated M/A/Q/q_m1 registers). Expected
// products and latencies are pushed to a scoreboard at request acceptance and
// compared when out_valid rises.
module tb_booth_seq_ctrl;
   import booth_pkg::*;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic       abort;
   logic       ld_en;
   logic [1:0] alu_op;
   logic       a_en;
   logic       shift_en;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;

   // Datapath registers; A carries one guard bit so M=-128 survives A-M
   logic [W:0]   a_r;
   logic [W-1:0] q_r;
   logic [W-1:0] m_r;
   logic         qm1_r;
   logic [2*W-1:0] prod;

   int n_tests = 0;
   int n_fail  = 0;
   int ecnt    = 0;
   int ld_cnt  = 0;
   int sh_cnt  = 0;
   int excl_viol = 0;
   int ov_rises  = 0;
   logic ov_prev = 1'b0;

   typedef struct {
      logic [2*W-1:0] prod;
      int             lat;
      int             acc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   booth_seq_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .abort     (abort),
      .q0        (q_r[0]),
      .q_m1      (qm1_r),
      .ld_en     (ld_en),
      .alu_op    (alu_op),
      .a_en      (a_en),
      .shift_en  (shift_en),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Behavioural Booth datapath
   always @(posedge clk) begin
      if (ld_en) begin
         m_r   <= op_a;
         q_r   <= op_b;
         a_r   <= '0;
         qm1_r <= 1'b0;
      end else begin
         if (a_en) begin
            if (alu_op == OP_ADD)      a_r <= a_r + {m_r[W-1], m_r};
            else if (alu_op == OP_SUB) a_r <= a_r - {m_r[W-1], m_r};
         end
         if (shift_en) {a_r, q_r, qm1_r} <= {a_r[W], a_r, q_r};
      end
   end
   assign prod = {a_r[W-1:0], q_r};

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Latency counted with the accepting cycle as cycle 1
   function automatic int exp_lat(input logic [W-1:0] b);
      int   n = 0;
      logic prev = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (b[i] != prev) n++;
         prev = b[i];
      end
`ifdef BOOTH_SEQ_CTRL_SKIP_EN
      return W + n + 2;
`else
      if (n < 0) return 0;
      return 2 * W + 2;
`endif
   endfunction

   // Monitor: sample away from the active edge
   always @(negedge clk) begin
      exp_t e;
      logic signed [2*W-1:0] p;
      if (reset_n) begin
         if (ld_en) ld_cnt++;
         if (shift_en) sh_cnt++;
         if (a_en && shift_en) excl_viol++;
         if (in_valid && in_ready) begin
            p = $signed(op_a) * $signed(op_b);
            e.prod = p;
            e.lat  = exp_lat(op_b);
            e.acc  = ecnt + 1;
            sb.push_back(e);
         end
         if (out_valid && !ov_prev) begin
            ov_rises++;
            chk("sb_outstanding", 32'(sb.size()), 1);
            if (sb.size() != 0) begin
               chk("product", 32'(prod), 32'(sb[0].prod));
               chk("latency", 32'(ecnt - sb[0].acc + 1), 32'(sb[0].lat));
            end
         end
         if (busy && abort) begin
            if (sb.size() != 0) e = sb.pop_front();
         end else if (out_valid && out_ready) begin
            if (sb.size() != 0) e = sb.pop_front();
         end
      end
      ov_prev = reset_n && out_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One multiply: request, wait for result, optional backpressure, handshake
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit idle_abort);
      int n;
      logic [2*W-1:0] p0;
      op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0; abort = idle_abort;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      if (idle_abort) chk("idle_abort_ignored", busy, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("ov_seen", out_valid, 1'b1);
      p0 = prod;
      for (int i = 0; i < hold; i++) begin
         chk("bp_ov_held", out_valid, 1'b1);
         chk("bp_prod_stable", 32'(prod), 32'(p0));
         chk("bp_in_ready", in_ready, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_idle", in_ready, 1'b1);
      chk("hs_ov_low", out_valid, 1'b0);
   endtask

   initial begin
      int ld0, sh0, ov0;
      reset_n = 1'b0; in_valid = 1'b1; abort = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0;

      // Reset with a pending request
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_in_ready", in_ready, 1'b1);
         chk("rst_busy", busy, 1'b0);
         chk("rst_ov", out_valid, 1'b0);
         chk("rst_enables", {ld_en, a_en, shift_en}, 3'b000);
         chk("rst_alu_op", alu_op, OP_NONE);
      end
      reset_n = 1'b1; in_valid = 1'b0;
      tick();
      chk("rst_no_load", busy, 1'b0);
      chk("rst_no_ld_pulse", ld_cnt, 0);

      // 3 x -2: a single SUB iteration
      run_mul(8'd3, 8'hFE, 0, 1'b0);

      // -128 x -128 with pulse counting
      ld0 = ld_cnt; sh0 = sh_cnt;
      run_mul(8'h80, 8'h80, 0, 1'b0);
      chk("ld_pulses", ld_cnt - ld0, 1);
      chk("shift_pulses", sh_cnt - sh0, W);

      // Backpressure for 5 cycles in DONE
      run_mul(8'h7F, 8'h81, 5, 1'b0);

      // Abort in the 4th OP cycle
      ov0 = ov_rises;
      op_a = 8'd3; op_b = 8'hFE; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_op_idle", in_ready, 1'b1);
      chk("abort_op_busy", busy, 1'b0);
      chk("abort_op_ov", out_valid, 1'b0);
      chk("abort_op_no_ov", ov_rises - ov0, 0);
      chk("abort_op_sb", 32'(sb.size()), 0);

      // Abort together with out_ready in DONE
      op_a = 8'd9; op_b = 8'd11; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int n = 0; n < 100 && !out_valid; n++) tick();
      chk("abort_done_reached", out_valid, 1'b1);
      abort = 1'b1; out_ready = 1'b1;
      tick();
      abort = 1'b0; out_ready = 1'b0;
      chk("abort_done_idle", in_ready, 1'b1);
      chk("abort_done_ov", out_valid, 1'b0);
      chk("abort_done_sb", 32'(sb.size()), 0);

      // Next request after aborts (abort held in IDLE is ignored)
      run_mul(8'd5, 8'd7, 0, 1'b1);

      // A few random operand pairs
      for (int i = 0; i < 4; i++) begin
         run_mul(8'($urandom), 8'($urandom), i % 2, 1'b0);
      end

      tick();
      chk("no_acc_with_shift", excl_viol, 0);
      chk("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Sequencing controller for the radix-2 Booth multiplier datapath.
- Drives the load, accumulate and shift enables of the datapath's enable-gated operand registers (M, Q, A, q_m1).
- Runs one WIDTH-iteration multiply per accepted request and presents a done handshake to the surrounding logic.
- Holds no operand data; it observes only the two Booth decode bits from the datapath.

Parameters:
- WIDTH, 8, operand width in bits; also the iteration count.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request to start a multiply; operands are present on the datapath inputs.
- in_ready  out  1  controller idle and able to accept a request.
- abort  in  1  cancel the operation in progress.
- q0  in  1  datapath Q[0].
- q_m1  in  1  datapath Q[-1] flag.
- ld_en  out  1  load M and Q from the operand inputs; clear A and q_m1.
- alu_op  out  2  datapath ALU select: 00 NONE, 01 ADD (A+M), 10 SUB (A-M).
- a_en  out  1  write the ALU result into A.
- shift_en  out  1  arithmetic right shift of {A,Q,q_m1} by 1.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  product {A,Q} is valid on the datapath.
- out_ready  in  1  consumer accepts the product.

Behaviour:
- States: IDLE, LOAD, OP, SHIFT, DONE.
- Registered state: the state register and the iteration counter cnt only.
- All other outputs are combinational decodes of the state, plus {q0,q_m1} in OP. There is no output-register latency.
- Reset (reset_n=0 at posedge):
  - state=IDLE, cnt=0.
  - Resulting outputs: in_ready=1; busy, out_valid, ld_en, a_en and shift_en all 0; alu_op=NONE.
  - Reset takes priority over every other input, including mid-operation.
- IDLE:
  - in_ready=1.
  - in_valid=1 → LOAD.
  - abort is ignored.
- LOAD:
  - ld_en=1 for exactly 1 cycle; cnt<=WIDTH.
  - Next state: OP.
- OP (decode of {q0,q_m1}):
  - 10: alu_op=SUB, a_en=1.
  - 01: alu_op=ADD, a_en=1.
  - 00 or 11: alu_op=NONE, a_en=0.
  - Next state: SHIFT.
- SHIFT:
  - shift_en=1; cnt<=cnt-1.
  - cnt==1 → DONE; otherwise → OP.
- DONE:
  - out_valid=1, held until out_ready=1.
  - out_ready=1 → IDLE.
  - Enables stay 0, so the datapath holds the product stable.
- abort=1 in LOAD, OP, SHIFT or DONE: next state IDLE, cnt<=0. No out_valid is produced, and the datapath contents are don't-care.
- abort and out_ready both 1 in DONE: abort wins. The result is IDLE with the product treated as discarded.
- Never assert a_en and shift_en in the same cycle.
- Never assert ld_en outside LOAD.
- Latency without the optional feature is fixed: out_valid rises 2*WIDTH+2 cycles after the accepting edge (18 for WIDTH=8).
- cnt never underflows. SHIFT is unreachable with cnt==0.

Optional Feature:
- Macro: BOOTH_SEQ_CTRL_SKIP_EN.
- Defined:
  - In OP, when {q0,q_m1} is 00 or 11, the controller performs the shift directly: shift_en=1, cnt<=cnt-1, a_en=0, alu_op=NONE.
  - It then stays in OP, or goes to DONE if cnt==1.
  - Latency becomes WIDTH + (number of add/sub iterations) + 2.
- Undefined: every iteration takes OP then SHIFT, giving fixed latency.

Decomposition:
- Package booth_pkg:
  - State enum: IDLE, LOAD, OP, SHIFT, DONE.
  - alu_op encoding constants: OP_NONE, OP_ADD, OP_SUB.
  - Default WIDTH.
- Sub-module booth_iter_cnt: down-counter with load value, dec, clear and a last (cnt==1) flag.

Test Plan (bench instantiates this block plus a behavioural datapath built from the team's enable-gated 8-bit registers):
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 → in_ready=1, busy=0, out_valid=0, all enables 0; no LOAD entered.
- Multiply 3 × 8'hFE (-2), feature off → exactly one SUB, out_valid 18 cycles after accept, product 16'hFFFA.
- Same operands with BOOTH_SEQ_CTRL_SKIP_EN → out_valid 11 cycles after accept, product 16'hFFFA.
- 8'h80 × 8'h80 (-128 × -128) → product 16'h4000. Check that shift_en pulses exactly 8 times and ld_en pulses once.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid held, product stable, in_ready=0. Then out_ready=1 → IDLE next cycle.
- abort asserted in the 4th OP cycle, and separately with out_ready=1 in DONE → IDLE next cycle, no out_valid. The next request (5 × 7) returns 16'h0023.
